// File: rtl/child_resp_collector_if.sv
// Handshake bundle between the child instance array and the parent consumer.
// The collector uses the master view; the children/parent side uses the slave view.
interface child_resp_collector_if #(
  parameter int N_CHILD = 5,
  parameter int DATA_W  = 16,
  parameter int SRC_W   = 3
);
  logic [N_CHILD-1:0]        child_valid;
  logic [N_CHILD*DATA_W-1:0] child_data;
  logic [N_CHILD-1:0]        child_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [SRC_W-1:0]          out_src;
  logic                      out_ready;

  modport master (
    input  child_valid, child_data, out_ready,
    output child_ready, out_valid, out_data, out_src
  );

  modport slave (
    output child_valid, child_data, out_ready,
    input  child_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/child_resp_collector.sv
// Round-robin collector that merges per-child response channels into one
// registered, source-tagged stream toward the parent.
module child_resp_collector #(
  parameter int N_CHILD = 5,
  parameter int DATA_W  = 16,
  parameter int SRC_W   = 3,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  child_resp_collector_if.master bus,
  output logic [CNT_W-1:0]     xfer_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state_p1;
  state_t             state_nxt;
  logic [SRC_W-1:0]   rr_ptr_p1;
  logic [DATA_W-1:0]  out_data_p1;
  logic [SRC_W-1:0]   out_src_p1;
  logic [CNT_W-1:0]   cnt_p1;

  logic               grant_vld_p0;
  logic [SRC_W-1:0]   grant_idx_p0;
  logic [DATA_W-1:0]  grant_data_p0;
  logic [DATA_W-1:0]  words_p0 [N_CHILD];
  logic               load_p0;
  logic               take_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] g);
    return (g == SRC_W'(N_CHILD - 1)) ? '0 : g + 1'b1;
  endfunction

  // ---- stage p0: combinational arbitration and handshake ----
  always_comb begin
    grant_vld_p0 = 1'b0;
    grant_idx_p0 = '0;
    for (int k = 0; k < N_CHILD; k++) begin
      int               idx;
      logic [SRC_W-1:0] idx_w;
      idx = int'(rr_ptr_p1) + k;
      if (idx >= N_CHILD) idx = idx - N_CHILD;
      idx_w = SRC_W'(idx);
      if (!grant_vld_p0 && bus.child_valid[idx_w]) begin
        grant_vld_p0 = 1'b1;
        grant_idx_p0 = idx_w;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_CHILD; k++) begin
      words_p0[k] = bus.child_data[k*DATA_W +: DATA_W];
    end
    grant_data_p0 = words_p0[grant_idx_p0];
  end

  // The held word may be replaced in the same cycle it drains.
  assign load_p0 = (state_p1 == EMPTY) || bus.out_ready;
  // Gating with rst_n keeps every child handshake off while reset is held.
  assign take_p0 = load_p0 && grant_vld_p0 && rst_n;

  always_comb begin
    bus.child_ready = '0;
    if (take_p0) bus.child_ready[grant_idx_p0] = 1'b1;
  end

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      EMPTY:   if (take_p0) state_nxt = FULL;
      FULL:    if (bus.out_ready && !grant_vld_p0) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // ---- stage p1: registered output word ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1    <= EMPTY;
      rr_ptr_p1   <= '0;
      out_data_p1 <= '0;
      out_src_p1  <= '0;
      cnt_p1      <= '0;
    end else begin
      state_p1 <= state_nxt;
      if (take_p0) begin
        out_data_p1 <= grant_data_p0;
        out_src_p1  <= grant_idx_p0;
        rr_ptr_p1   <= next_ptr(grant_idx_p0);
        cnt_p1      <= sat_inc(cnt_p1);
      end
    end
  end

  assign bus.out_valid = (state_p1 == FULL);
  assign bus.out_data  = out_data_p1;
  assign bus.out_src   = out_src_p1;
  assign xfer_cnt      = cnt_p1;

endmodule

// File: tb/tb_child_resp_collector.sv
// Bench for child_resp_collector: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_child_resp_collector;
  localparam int N  = 5;
  localparam int DW = 16;
  localparam int SW = 3;
  localparam int CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  child_resp_collector_if #(.N_CHILD(N), .DATA_W(DW), .SRC_W(SW)) bus ();
  logic [CW-1:0] xfer_cnt;

  child_resp_collector #(.N_CHILD(N), .DATA_W(DW), .SRC_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .xfer_cnt(xfer_cnt)
  );

  // Narrow-counter instance used to reach counter saturation quickly.
  child_resp_collector_if #(.N_CHILD(2), .DATA_W(8), .SRC_W(1)) bus_s ();
  logic [1:0] sat_cnt;

  child_resp_collector #(.N_CHILD(2), .DATA_W(8), .SRC_W(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus_s), .xfer_cnt(sat_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Child-side stimulus state and reference model state
  bit            cv [N];
  logic [DW-1:0] cd [N];
  bit            or_r;
  bit            sticky;
  int            m_ptr;
  bit            m_full;
  logic [DW-1:0] m_data;
  int            m_src;
  int            m_cnt;
  logic [N-1:0]  got_rdy;
  logic [N-1:0]  exp_rdy;

  function automatic int m_grant();
    if (!rst_n) return -1;
    if (m_full && !or_r) return -1;
    for (int off = 0; off < N; off++) begin
      int c;
      c = (m_ptr + off) % N;
      if (cv[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_full = 0; m_data = '0; m_src = 0; m_cnt = 0;
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      bus.child_valid[i] = cv[i];
      bus.child_data[i*DW +: DW] = cd[i];
    end
    bus.out_ready = or_r;
  endtask

  // Drives one clock cycle, captures child_ready mid-cycle, advances the model.
  task automatic cycle();
    int g;
    apply_inputs();
    @(negedge clk);
    g = m_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    got_rdy = bus.child_ready;
    @(posedge clk);
    if (g >= 0) begin
      m_full = 1;
      m_data = cd[g];
      m_src  = g;
      m_ptr  = (g + 1) % N;
      if (m_cnt < CNT_MAX) m_cnt++;
      if (!sticky) cv[g] = 0;
    end else if (m_full && or_r) begin
      m_full = 0;
    end
    #1;
  endtask

  task automatic clear_children();
    for (int i = 0; i < N; i++) begin cv[i] = 0; cd[i] = '0; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_children();
    apply_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) cv[i] = 1;
    or_r = 1;
    apply_inputs();
    #1;
    n_checks++;
    if (bus.child_ready !== '0) begin n_errors++; $display("FAIL reset_ready got=%b exp=0", bus.child_ready); end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || xfer_cnt !== '0 || bus.out_data !== '0 || bus.out_src !== '0) begin
      n_errors++;
      $display("FAIL reset_state got v=%b cnt=%0d d=%h s=%0d exp all zero", bus.out_valid, xfer_cnt, bus.out_data, bus.out_src);
    end
    clear_children();
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 20; k++) begin
      cycle();
      n_checks++;
      if (got_rdy !== '0 || bus.out_valid !== 1'b0 || xfer_cnt !== '0) begin
        n_errors++;
        $display("FAIL idle cyc=%0d got rdy=%b v=%b cnt=%0d exp 0/0/0", k, got_rdy, bus.out_valid, xfer_cnt);
      end
    end
  endtask

  task automatic test_single();
    cv[3] = 1; cd[3] = 16'h00A3; or_r = 1; sticky = 0;
    cycle();
    n_checks++;
    if (got_rdy !== 5'b01000) begin n_errors++; $display("FAIL single_ready got=%b exp=01000", got_rdy); end
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h00A3 || bus.out_src !== 3'd3 || xfer_cnt !== 16'd1) begin
      n_errors++;
      $display("FAIL single_out got v=%b d=%h s=%0d cnt=%0d exp 1/00a3/3/1", bus.out_valid, bus.out_data, bus.out_src, xfer_cnt);
    end
    cycle();
    n_checks++;
    if (got_rdy !== '0 || bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL single_drain got rdy=%b v=%b exp 0/0", got_rdy, bus.out_valid);
    end
  endtask

  task automatic test_all_valid();
    int seq [6] = '{0, 1, 2, 3, 4, 0};
    do_reset();
    sticky = 1; or_r = 1;
    for (int i = 0; i < N; i++) begin cv[i] = 1; cd[i] = 16'h1000 + 16'(i); end
    for (int k = 0; k < 6; k++) begin
      cycle();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_src !== 3'(seq[k]) || bus.out_data !== 16'h1000 + 16'(seq[k])) begin
        n_errors++;
        $display("FAIL all_valid k=%0d got v=%b s=%0d d=%h exp 1/%0d/%h", k, bus.out_valid, bus.out_src, bus.out_data, seq[k], 16'h1000 + 16'(seq[k]));
      end
    end
    n_checks++;
    if (xfer_cnt !== 16'd6) begin n_errors++; $display("FAIL all_valid_cnt got=%0d exp=6", xfer_cnt); end
    sticky = 0;
  endtask

  task automatic test_backpressure();
    clear_children();
    cv[1] = 1; cd[1] = 16'h2001;
    cv[2] = 1; cd[2] = 16'h2002;
    or_r = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      n_checks++;
      if (got_rdy !== '0 || bus.out_valid !== 1'b1 || bus.out_data !== 16'h1000 || bus.out_src !== 3'd0) begin
        n_errors++;
        $display("FAIL bp_hold k=%0d got rdy=%b v=%b d=%h s=%0d exp 0/1/1000/0", k, got_rdy, bus.out_valid, bus.out_data, bus.out_src);
      end
    end
    or_r = 1;
    cycle();
    n_checks++;
    if (got_rdy !== 5'b00010 || bus.out_src !== 3'd1 || bus.out_data !== 16'h2001) begin
      n_errors++;
      $display("FAIL bp_release1 got rdy=%b s=%0d d=%h exp 00010/1/2001", got_rdy, bus.out_src, bus.out_data);
    end
    cycle();
    n_checks++;
    if (got_rdy !== 5'b00100 || bus.out_src !== 3'd2 || bus.out_data !== 16'h2002 || bus.out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_release2 got rdy=%b s=%0d d=%h v=%b exp 00100/2/2002/1", got_rdy, bus.out_src, bus.out_data, bus.out_valid);
    end
  endtask

  task automatic test_wrap();
    clear_children();
    cv[3] = 1; cd[3] = 16'h3003; or_r = 1;
    cycle();
    cv[0] = 1; cd[0] = 16'h3000;
    cv[4] = 1; cd[4] = 16'h3004;
    cycle();
    n_checks++;
    if (bus.out_src !== 3'd4 || bus.out_data !== 16'h3004) begin
      n_errors++;
      $display("FAIL wrap_first got s=%0d d=%h exp 4/3004", bus.out_src, bus.out_data);
    end
    cycle();
    n_checks++;
    if (bus.out_src !== 3'd0 || bus.out_data !== 16'h3000) begin
      n_errors++;
      $display("FAIL wrap_second got s=%0d d=%h exp 0/3000", bus.out_src, bus.out_data);
    end
    cycle();
  endtask

  task automatic test_async_reset();
    clear_children();
    cv[2] = 1; cd[2] = 16'hBEEF; or_r = 1;
    cycle();
    or_r = 0;
    cv[1] = 1; cd[1] = 16'h1111;
    cycle();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hBEEF) begin
      n_errors++;
      $display("FAIL arst_setup got v=%b d=%h exp 1/beef", bus.out_valid, bus.out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_src !== '0 || xfer_cnt !== '0 || bus.child_ready !== '0) begin
      n_errors++;
      $display("FAIL arst_immediate got v=%b d=%h s=%0d cnt=%0d rdy=%b exp all zero",
               bus.out_valid, bus.out_data, bus.out_src, xfer_cnt, bus.child_ready);
    end
    model_reset();
    clear_children();
    or_r = 1;
    apply_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_checks++;
      if (bus.out_valid !== 1'b0 || xfer_cnt !== '0) begin
        n_errors++;
        $display("FAIL arst_after k=%0d got v=%b d=%h cnt=%0d exp v=0 cnt=0", k, bus.out_valid, bus.out_data, xfer_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    bus_s.child_valid = 2'b01;
    bus_s.child_data  = 16'h0055;
    bus_s.out_ready   = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      int exp_c;
      @(posedge clk);
      #1;
      exp_c = (k > 3) ? 3 : k;
      n_checks++;
      if (sat_cnt !== 2'(exp_c)) begin
        n_errors++;
        $display("FAIL saturation k=%0d got=%0d exp=%0d", k, sat_cnt, exp_c);
      end
    end
    bus_s.child_valid = 2'b00;
  endtask

  task automatic test_random();
    clear_children();
    sticky = 0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!cv[i] && $urandom_range(1, 0) == 1) begin
          cv[i] = 1;
          cd[i] = DW'($urandom);
        end
      end
      or_r = ($urandom_range(3, 0) != 0);
      cycle();
      n_checks++;
      if (got_rdy !== exp_rdy) begin
        n_errors++;
        $display("FAIL rand_ready k=%0d got=%b exp=%b", k, got_rdy, exp_rdy);
      end
      n_checks++;
      if (bus.out_valid !== m_full || xfer_cnt !== CW'(m_cnt)) begin
        n_errors++;
        $display("FAIL rand_state k=%0d got v=%b cnt=%0d exp v=%b cnt=%0d", k, bus.out_valid, xfer_cnt, m_full, m_cnt);
      end
      if (m_full) begin
        n_checks++;
        if (bus.out_data !== m_data || bus.out_src !== SW'(m_src)) begin
          n_errors++;
          $display("FAIL rand_data k=%0d got d=%h s=%0d exp d=%h s=%0d", k, bus.out_data, bus.out_src, m_data, m_src);
        end
      end
    end
  endtask

  initial begin
    bus_s.child_valid = '0;
    bus_s.child_data  = '0;
    bus_s.out_ready   = 1'b0;
    sticky = 0;
    or_r   = 0;
    clear_children();
    model_reset();
    test_reset();
    test_single();
    test_all_valid();
    test_backpressure();
    test_wrap();
    test_async_reset();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/child_resp_collector.md
Name: child_resp_collector

Overview:
- Upward-direction counterpart to the root fan-out that instantiates five child sub-modules. The root broadcasts down to the children; this block carries the children's results back up to the root.
- Collects response words from N_CHILD child instances over per-child valid/ready channels.
- Arbitrates round-robin and presents one registered response stream, tagged with the source index, to the parent.
- Sits inside the root module, between the child instance array and the parent-level consumer.

Parameters:
- N_CHILD, 5, number of child response channels (2..8).
- DATA_W, 16, width of one response word.
- SRC_W, 3, width of the source index; must satisfy 2^SRC_W >= N_CHILD.
- CNT_W, 16, width of the accepted-transaction counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- child_valid  input  N_CHILD  per-child response valid.
- child_data  input  N_CHILD*DATA_W  per-child response word; child i occupies bits [i*DATA_W +: DATA_W].
- child_ready  output  N_CHILD  per-child accept; at most one bit is high in any cycle.
- out_valid  output  1  registered response valid toward the parent.
- out_data  output  DATA_W  registered response word.
- out_src  output  SRC_W  index of the child that produced out_data.
- out_ready  input  1  parent accepts the current output word.
- xfer_cnt  output  CNT_W  number of words accepted from children since reset.

Behaviour:
- Reset:
  - Asserting rst_n low clears all state immediately, independent of clk.
  - Reset values: out_valid=0, out_data=0, out_src=0, xfer_cnt=0, rr_ptr=0, state=EMPTY.
  - child_ready is combinational and is 0 while in reset.
  - Reset asserted mid-transfer discards the held word; no child handshake completes in that cycle.
- State machine (2 states, held in a register):
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Load condition: load = (state==EMPTY) || (state==FULL && out_ready).
- Arbitration:
  - Combinational.
  - Searches child_valid starting at index rr_ptr, ascending, wrapping from N_CHILD-1 to 0.
  - The first asserted index g is the grant.
  - child_ready[g] = load && child_valid[g]; all other child_ready bits are 0.
- On the clock edge when a grant exists and load=1:
  - out_data <= child_data[g]; out_src <= g; state <= FULL.
  - rr_ptr <= (g==N_CHILD-1) ? 0 : g+1.
  - xfer_cnt increments and saturates at all-ones; it never wraps.
- On the edge with state==FULL, out_ready=1 and no grant:
  - state <= EMPTY; out_data and out_src hold their last value.
- Simultaneous drain and refill: state FULL, out_ready=1 and a grant present.
  - State stays FULL and the new word replaces the old in the same cycle.
  - Sustained throughput is one word per cycle.
- Back-pressure: state FULL and out_ready=0.
  - out_data and out_src are held stable; all child_ready bits are 0; rr_ptr is unchanged.
- Latency: a child word is visible on out_* one cycle after its child handshake (child_valid && child_ready).
- No grant: rr_ptr is unchanged.
- Child-side rules:
  - Children hold child_valid and child_data stable until accepted.
  - Data is sampled only on handshake.
- Fairness: any child that holds valid is served within N_CHILD accepted words.

Test Plan:
- Reset then idle: rst_n low, then high, child_valid=0 → out_valid=0, xfer_cnt=0, child_ready=0 for 20 cycles.
- Single child: child 3 valid with data 0x00A3, out_ready=1 → child_ready=5'b01000 for one cycle; next cycle out_valid=1, out_data=0x00A3, out_src=3, xfer_cnt=1.
- All five valid continuously, out_ready=1, data=0x1000+i → out_src sequence 0,1,2,3,4,0, one word per cycle, no gaps.
- Back-pressure: out_ready=0 for 4 cycles while children 1 and 2 are valid → out_data frozen, child_ready=0. Release out_ready → child 1 then child 2 are served in consecutive cycles.
- Pointer wrap: rr_ptr=4 after serving child 3; children 0 and 4 valid → 4 is served first, then 0.
- Async reset while out_valid=1 and out_ready=0 → out_valid drops before the next clk edge; after release, the previously held word is never delivered. Then preload xfer_cnt near max (force 0xFFFE) and accept 3 words → xfer_cnt reads 0xFFFF.
